// File: rtl/pong_game_ctrl.sv
// ---------------------------------------------------------------------------
// PongGameCtrl -- game-flow controller for the pong demo.
//
// Sequences a game through IDLE -> SERVE -> PLAY -> MISS -> (SERVE | OVER),
// tracks score (3-digit BCD), remaining lives and ball speed, and tells the
// ball datapath when to move and when to reload its serve position.
//
// Ports
//   clk         25 MHz pixel clock, the only clock
//   reset       synchronous active-high reset
//   frame_tick  one-cycle pulse per video frame
//   start_btn   raw asynchronous start button (active-high)
//   hit         one-cycle pulse: ball bounced off the paddle
//   miss        one-cycle pulse: ball passed the paddle row
//   state       IDLE=0, SERVE=1, PLAY=2, MISS=3, OVER=4
//   ball_enable ball may move (PLAY only)
//   serve_load  one-cycle pulse on the first cycle of each SERVE visit
//   speed       ball pixels per frame, 1..MAX_SPEED
//   lives       remaining lives
//   score_bcd   score, [11:8] hundreds .. [3:0] units
//   game_over   high only in OVER
// ---------------------------------------------------------------------------
module pong_game_ctrl #(
   parameter int SERVE_FRAMES   = 60,
   parameter int LIVES          = 3,
   parameter int HITS_PER_LEVEL = 8,
   parameter int MAX_SPEED      = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        frame_tick,
   input  logic        start_btn,
   input  logic        hit,
   input  logic        miss,
   output logic [2:0]  state,
   output logic        ball_enable,
   output logic        serve_load,
   output logic [2:0]  speed,
   output logic [1:0]  lives,
   output logic [11:0] score_bcd,
   output logic        game_over
);

   localparam int FW = $clog2(SERVE_FRAMES + 1);
   localparam int HW = $clog2(HITS_PER_LEVEL + 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SERVE = 3'd1,
      PLAY  = 3'd2,
      MISS  = 3'd3,
      OVER  = 3'd4
   } GameState;

   GameState curState;
   GameState nextState;

   logic          syncA;
   logic          syncB;
   logic          syncPrev;
   logic          startEvt;
   logic          enterServe;
   logic [FW-1:0] frameCnt;
   logic [HW-1:0] hitCnt;

   // Decimal increment of the 3-digit score; sticks at 999 rather than
   // wrapping so a long game never appears to reset the score.
   function automatic logic [11:0] bcdInc(input logic [11:0] v);
      logic [3:0] d0;
      logic [3:0] d1;
      logic [3:0] d2;
      d0 = v[3:0];
      d1 = v[7:4];
      d2 = v[11:8];
      if (v != 12'h999) begin
         if (d0 != 4'd9) begin
            d0 = d0 + 4'd1;
         end else begin
            d0 = 4'd0;
            if (d1 != 4'd9) begin
               d1 = d1 + 4'd1;
            end else begin
               d1 = 4'd0;
               d2 = d2 + 4'd1;
            end
         end
      end
      return {d2, d1, d0};
   endfunction

   // The start button is asynchronous: two flops bring it into the clk
   // domain, and a third remembers the previous level so only a press
   // (rising edge) produces a start event, not a held button.
   always_ff @(posedge clk) begin
      if (reset) begin
         syncA    <= 1'b0;
         syncB    <= 1'b0;
         syncPrev <= 1'b0;
      end else begin
         syncA    <= start_btn;
         syncB    <= syncA;
         syncPrev <= syncB;
      end
   end

   assign startEvt   = syncB & ~syncPrev;
   assign enterServe = (nextState == SERVE) && (curState != SERVE);

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         curState <= IDLE;
      end else begin
         curState <= nextState;
      end
   end

   // Next-state logic. Miss is checked before anything else in PLAY so a
   // simultaneous hit is simply lost. Unknown codes fall back to IDLE.
   always_comb begin
      nextState = IDLE;
      case (curState)
         IDLE:    nextState = startEvt ? SERVE : IDLE;
         SERVE:   nextState = (frame_tick && frameCnt == FW'(SERVE_FRAMES - 1))
                              ? PLAY : SERVE;
         PLAY:    nextState = miss ? MISS : PLAY;
         MISS:    nextState = frame_tick ? ((lives == 2'd0) ? OVER : SERVE)
                                         : MISS;
         OVER:    nextState = startEvt ? SERVE : OVER;
         default: nextState = IDLE;
      endcase
   end

   // Game datapath: serve pulse, frame counter, score, lives and speed.
   // A serve entered from IDLE or OVER starts a fresh game; a serve after a
   // lost ball keeps score, speed and hit progress. Lives drop on the same
   // edge as the PLAY->MISS move so MISS can decide OVER from the new value.
   always_ff @(posedge clk) begin
      if (reset) begin
         serve_load <= 1'b0;
         frameCnt   <= '0;
         hitCnt     <= '0;
         speed      <= 3'd1;
         lives      <= 2'(LIVES);
         score_bcd  <= 12'h000;
      end else begin
         serve_load <= enterServe;

         if (enterServe) begin
            frameCnt <= '0;
         end else if (curState == SERVE && frame_tick) begin
            frameCnt <= frameCnt + FW'(1);
         end

         if (enterServe && (curState == IDLE || curState == OVER)) begin
            score_bcd <= 12'h000;
            lives     <= 2'(LIVES);
            speed     <= 3'd1;
            hitCnt    <= '0;
         end else if (curState == PLAY) begin
            if (miss) begin
               lives <= lives - 2'd1;
            end else if (hit) begin
               score_bcd <= bcdInc(score_bcd);
               if (hitCnt == HW'(HITS_PER_LEVEL - 1)) begin
                  hitCnt <= '0;
                  if (speed < 3'(MAX_SPEED)) begin
                     speed <= speed + 3'd1;
                  end
               end else begin
                  hitCnt <= hitCnt + HW'(1);
               end
            end
         end
      end
   end

   assign state       = curState;
   assign ball_enable = (curState == PLAY);
   assign game_over   = (curState == OVER);

endmodule

// File: tb/tb_pong_game_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pong_game_ctrl -- self-checking bench for pong_game_ctrl (default
// parameters: 60 serve frames, 3 lives, 8 hits per level, max speed 4).
//
// Every cycle is driven by applyStimulus, which pushes the expected outputs
// for that cycle onto a queue; checkOutput pops and compares after the edge.
// Score and speed are predicted from the count of hits that landed this game.
// ---------------------------------------------------------------------------
module tb_pong_game_ctrl;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_SERVE = 3'd1;
   localparam logic [2:0] S_PLAY  = 3'd2;
   localparam logic [2:0] S_MISS  = 3'd3;
   localparam logic [2:0] S_OVER  = 3'd4;

   logic        clk = 1'b0;
   logic        reset;
   logic        frame_tick;
   logic        start_btn;
   logic        hit;
   logic        miss;
   logic [2:0]  state;
   logic        ball_enable;
   logic        serve_load;
   logic [2:0]  speed;
   logic [1:0]  lives;
   logic [11:0] score_bcd;
   logic        game_over;

   pong_game_ctrl dut (
      .clk         (clk),
      .reset       (reset),
      .frame_tick  (frame_tick),
      .start_btn   (start_btn),
      .hit         (hit),
      .miss        (miss),
      .state       (state),
      .ball_enable (ball_enable),
      .serve_load  (serve_load),
      .speed       (speed),
      .lives       (lives),
      .score_bcd   (score_bcd),
      .game_over   (game_over)
   );

   // 25 MHz clock.
   always #20 clk = ~clk;

   typedef struct {
      logic [2:0]  st;
      logic        sl;
      logic [2:0]  spd;
      logic [1:0]  lv;
      logic [11:0] score;
   } ExpRec;

   typedef struct {
      logic       t;
      logic       h;
      logic       m;
      logic [2:0] st;
      logic       sl;
      int         dHits;
      int         dLives;
   } Vec;

   ExpRec expQ[$];
   Vec    tbl[6];
   int    checks  = 0;
   int    passes  = 0;
   int    tbHits  = 0;
   int    tbLives = 3;

   function automatic logic [11:0] toBcd(input int n);
      int m;
      m = (n > 999) ? 999 : n;
      return {4'(m / 100), 4'((m / 10) % 10), 4'(m % 10)};
   endfunction

   function automatic logic [2:0] speedOf(input int n);
      int s;
      s = 1 + n / 8;
      if (s > 4) s = 4;
      return 3'(s);
   endfunction

   task automatic checkOne(input string name, input int act, input int exp);
      checks++;
      if (act == exp) passes++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
   endtask

   // Pop the oldest expectation and compare it with what the DUT shows now.
   task automatic checkOutput();
      ExpRec e;
      if (expQ.size() == 0) begin
         checkOne("scoreboard_empty", 1, 0);
      end else begin
         e = expQ.pop_front();
         checkOne("state",       int'(state),       int'(e.st));
         checkOne("ball_enable", int'(ball_enable), int'(e.st == S_PLAY));
         checkOne("serve_load",  int'(serve_load),  int'(e.sl));
         checkOne("speed",       int'(speed),       int'(e.spd));
         checkOne("lives",       int'(lives),       int'(e.lv));
         checkOne("score_bcd",   int'(score_bcd),   int'(e.score));
         checkOne("game_over",   int'(game_over),   int'(e.st == S_OVER));
      end
   endtask

   // Drive one cycle of inputs, record what should appear after the edge.
   task automatic applyStimulus(input logic r, input logic s, input logic t,
                                input logic h, input logic m,
                                input logic [2:0] st, input logic sl);
      ExpRec e;
      reset      = r;
      start_btn  = s;
      frame_tick = t;
      hit        = h;
      miss       = m;
      e.st    = st;
      e.sl    = sl;
      e.spd   = speedOf(tbHits);
      e.lv    = 2'(tbLives);
      e.score = toBcd(tbHits);
      expQ.push_back(e);
      @(posedge clk);
      #1;
      checkOutput();
   endtask

   // From the first SERVE cycle: 59 ticks hold SERVE, the 60th enters PLAY.
   task automatic serveToPlay();
      for (int i = 0; i < 59; i++) applyStimulus(0, 0, 1, 0, 0, S_SERVE, 0);
      applyStimulus(0, 0, 1, 0, 0, S_PLAY, 0);
   endtask

   task automatic hitOnce();
      tbHits++;
      applyStimulus(0, 0, 0, 1, 0, S_PLAY, 0);
   endtask

   initial begin
      // Simultaneous hit+miss, then the lost-ball serve.
      tbl[0] = '{t: 0, h: 1, m: 1, st: S_MISS,  sl: 0, dHits: 0, dLives: -1};
      tbl[1] = '{t: 0, h: 0, m: 0, st: S_MISS,  sl: 0, dHits: 0, dLives: 0};
      tbl[2] = '{t: 0, h: 1, m: 0, st: S_MISS,  sl: 0, dHits: 0, dLives: 0};
      tbl[3] = '{t: 1, h: 0, m: 0, st: S_SERVE, sl: 1, dHits: 0, dLives: 0};
      tbl[4] = '{t: 0, h: 0, m: 0, st: S_SERVE, sl: 0, dHits: 0, dLives: 0};
      tbl[5] = '{t: 0, h: 1, m: 1, st: S_SERVE, sl: 0, dHits: 0, dLives: 0};

      reset = 1'b1; start_btn = 1'b0; frame_tick = 1'b0; hit = 1'b0; miss = 1'b0;

      // Reset values.
      applyStimulus(1, 0, 0, 0, 0, S_IDLE, 0);
      applyStimulus(1, 0, 0, 0, 0, S_IDLE, 0);

      // Held start button: SERVE after the third edge, one serve_load pulse.
      applyStimulus(0, 1, 0, 0, 0, S_IDLE, 0);
      applyStimulus(0, 1, 0, 0, 0, S_IDLE, 0);
      applyStimulus(0, 1, 0, 0, 0, S_SERVE, 1);
      applyStimulus(0, 1, 0, 0, 0, S_SERVE, 0);
      checkOne("start_lives", int'(lives), 3);
      checkOne("start_score", int'(score_bcd), 0);

      // Hit/miss ignored in SERVE, then the serve countdown.
      applyStimulus(0, 0, 0, 1, 1, S_SERVE, 0);
      serveToPlay();
      checkOne("play_ball_enable", int'(ball_enable), 1);

      // Frame ticks are ignored during PLAY.
      applyStimulus(0, 0, 1, 0, 0, S_PLAY, 0);

      // Speed levels.
      for (int i = 0; i < 8; i++) hitOnce();
      checkOne("score_after_8", int'(score_bcd), 12'h008);
      checkOne("speed_after_8", int'(speed), 2);
      for (int i = 0; i < 16; i++) hitOnce();
      checkOne("score_after_24", int'(score_bcd), 12'h024);
      checkOne("speed_after_24", int'(speed), 4);
      for (int i = 0; i < 8; i++) hitOnce();
      checkOne("speed_saturated", int'(speed), 4);

      // Table: miss wins over hit, MISS waits for a tick, score is kept.
      for (int i = 0; i < 6; i++) begin
         tbHits  += tbl[i].dHits;
         tbLives += tbl[i].dLives;
         applyStimulus(0, 0, tbl[i].t, tbl[i].h, tbl[i].m, tbl[i].st, tbl[i].sl);
      end
      checkOne("score_kept", int'(score_bcd), 12'h032);
      serveToPlay();

      // Decimal carry and saturation.
      while (tbHits < 99) hitOnce();
      checkOne("score_099", int'(score_bcd), 12'h099);
      hitOnce();
      checkOne("score_100", int'(score_bcd), 12'h100);
      while (tbHits < 999) hitOnce();
      checkOne("score_999", int'(score_bcd), 12'h999);
      hitOnce();
      checkOne("score_sat", int'(score_bcd), 12'h999);

      // Lose the remaining two lives.
      tbLives--;
      applyStimulus(0, 0, 0, 0, 1, S_MISS, 0);
      applyStimulus(0, 0, 1, 0, 0, S_SERVE, 1);
      serveToPlay();
      tbLives--;
      applyStimulus(0, 0, 0, 0, 1, S_MISS, 0);
      applyStimulus(0, 0, 1, 0, 0, S_OVER, 0);
      checkOne("over_flag", int'(game_over), 1);
      checkOne("over_lives", int'(lives), 0);
      applyStimulus(0, 0, 1, 1, 1, S_OVER, 0);

      // Restart from OVER re-initialises the game.
      applyStimulus(0, 1, 0, 0, 0, S_OVER, 0);
      applyStimulus(0, 1, 0, 0, 0, S_OVER, 0);
      tbHits  = 0;
      tbLives = 3;
      applyStimulus(0, 1, 0, 0, 0, S_SERVE, 1);
      checkOne("restart_lives", int'(lives), 3);
      checkOne("restart_score", int'(score_bcd), 0);
      serveToPlay();
      for (int i = 0; i < 3; i++) hitOnce();

      // Reset in the middle of PLAY aborts the game immediately.
      tbHits  = 0;
      tbLives = 3;
      applyStimulus(1, 0, 0, 1, 0, S_IDLE, 0);
      applyStimulus(0, 0, 0, 0, 0, S_IDLE, 0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/pong_game_ctrl.md
PONG_GAME_CTRL -- requirements
Module: pong_game_ctrl

Interface
REQ-001 SHALL have parameter SERVE_FRAMES, default 60: frames the ball is held at the serve position before play.
REQ-002 SHALL have parameter LIVES, default 3, legal 1..3: lives granted at game start.
REQ-003 SHALL have parameter HITS_PER_LEVEL, default 8: paddle hits per speed increase.
REQ-004 SHALL have parameter MAX_SPEED, default 4, legal 1..7: speed saturation value.
REQ-005 SHALL have port clk  in  1  25 MHz pixel clock; the only clock.
REQ-006 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-007 SHALL have port frame_tick  in  1  one-cycle pulse per video frame.
REQ-008 SHALL have port start_btn  in  1  raw asynchronous start button, active-high.
REQ-009 SHALL have port hit  in  1  one-cycle pulse when the ball bounces off the paddle.
REQ-010 SHALL have port miss  in  1  one-cycle pulse when the ball passes the paddle row.
REQ-011 SHALL have port state  out  3  IDLE=0, SERVE=1, PLAY=2, MISS=3, OVER=4.
REQ-012 SHALL have port ball_enable  out  1  ball may move; high only in PLAY.
REQ-013 SHALL have port serve_load  out  1  one-cycle pulse: datapath reloads the ball serve position.
REQ-014 SHALL have port speed  out  3  ball pixels per frame, 1..MAX_SPEED.
REQ-015 SHALL have port lives  out  2  remaining lives.
REQ-016 SHALL have port score_bcd  out  12  3-digit BCD score; [11:8] hundreds, [3:0] units.
REQ-017 SHALL have port game_over  out  1  high only in OVER.

Function
REQ-018 SHALL pass start_btn through a 2-flop synchronizer, then a rising-edge detector (start_evt).
REQ-019 SHALL take the IDLE->SERVE transition on the clock edge where start_evt=1, with state=SERVE after the 3rd rising clk edge from the first edge sampling start_btn=1.
REQ-020 SHALL, on every entry to SERVE from IDLE or OVER, set score_bcd=0x000, lives=LIVES, speed=1 and hit counter=0.
REQ-021 SHALL assert serve_load in exactly the first cycle of every SERVE visit.
REQ-022 SHALL, in SERVE, clear the frame counter on entry, count frame_tick pulses, and go to PLAY on the tick that makes the count equal SERVE_FRAMES.
REQ-023 SHALL, in PLAY, on hit, increment score_bcd with decimal carry per digit, saturating at 0x999.
REQ-024 SHALL, in PLAY, on hit, increment the hit counter; on the hit that makes it equal HITS_PER_LEVEL, clear it and raise speed by 1, saturating at MAX_SPEED.
REQ-025 SHALL, in PLAY, on miss, go to MISS and decrement lives by 1 on the same edge.
REQ-026 SHALL give miss priority when hit and miss are high in the same PLAY cycle, so that the hit is ignored (no score, counter or speed change).
REQ-027 SHALL, in MISS, wait for the next frame_tick, then go to OVER if lives=0, else to SERVE (score and speed kept).
REQ-028 SHALL, in OVER, go to SERVE with re-initialisation per REQ-020 on start_evt.
REQ-029 SHALL ignore start_evt in SERVE, PLAY and MISS.
REQ-030 SHALL ignore hit and miss outside PLAY.
REQ-031 SHALL ignore frame_tick outside SERVE and MISS.
REQ-032 SHALL register all outputs, with ball_enable, game_over and state decoded from the registered state, so no combinational input-to-output path exists.
REQ-033 SHALL decode illegal state codes to IDLE on the next edge.

Reset
REQ-034 SHALL, with reset high at a clk edge, set state=IDLE, ball_enable=0, serve_load=0, game_over=0, speed=1, lives=LIVES, score_bcd=0x000, all counters and synchronizer flops 0.
REQ-035 SHALL have reset take priority over all inputs, aborting any state mid-operation.
REQ-036 SHALL not emit a serve_load pulse on reset.

Verification
REQ-037 SHALL cover: reset, start_btn held high -> state=SERVE 3 clocks later; serve_load=1 for one cycle; lives=3, score=0x000, speed=1.
REQ-038 SHALL cover: in SERVE, 59 frame_ticks -> still SERVE; 60th tick -> PLAY next cycle, ball_enable=1.
REQ-039 SHALL cover: in PLAY, 8 hits -> score_bcd=0x008, speed=2; 16 more hits (24 total) -> score_bcd=0x024, speed=4; 8 further hits -> speed stays 4.
REQ-040 SHALL cover: score preloaded to 0x999 by hits, one more hit -> 0x999 (saturated); one hit from 0x099 -> 0x100.
REQ-041 SHALL cover: hit and miss in the same cycle -> MISS, lives 3->2, score unchanged; the next frame_tick -> SERVE with serve_load pulse, score kept.
REQ-042 SHALL cover: three misses -> OVER, game_over=1, lives=0; start_btn -> SERVE with lives=3, score=0x000; reset asserted mid-PLAY -> IDLE next edge.
